onchip_scratchpad: RTL and testbench
====================================

Name: onchip_scratchpad

Overview:
Parametrised single-clock scratchpad RAM for the neural engine datapath. Successor to the 1K x 16 on-chip memory.
- Independent write and read pointers, so one write and one read can proceed in the same cycle.
- Read bursts with a programmable per-word wait-state count, delivered over a req/ready/valid handshake.
- Sits between the DMA/loader and the MAC array operand fetch.

Parameters:
DATA_W, 16, data word width
DEPTH, 1024, number of words; need not be a power of 2
ADDR_W, $clog2(DEPTH), address width
WAIT_W, 2, width of wait-state count (0..2^WAIT_W-1 extra cycles per word)
LEN_W, 4, width of burst length field (burst = rd_len+1 words)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
wr_en  in  1  write strobe, always accepted
wr_data  in  DATA_W  write data
wr_addr  in  ADDR_W  external write address
wr_use_ext  in  1  1: write to wr_addr; 0: write to wr_ptr and post-increment
wr_ptr_load  in  1  load wr_ptr from ptr_base
rd_ptr_load  in  1  load rd_ptr from ptr_base
ptr_base  in  ADDR_W  pointer load value
rd_req  in  1  burst request
rd_ready  out  1  high in IDLE only; request accepted when rd_req && rd_ready
rd_addr  in  ADDR_W  external burst start address
rd_use_ext  in  1  1: burst starts at rd_addr; 0: burst starts at rd_ptr
rd_len  in  LEN_W  burst length minus one
rd_wait  in  WAIT_W  wait cycles inserted before each word
rd_valid  out  1  one-cycle pulse per delivered word
rd_data  out  DATA_W  read data, held between pulses
rd_last  out  1  asserted with rd_valid on the final word of a burst
wr_par_flip  in  1  inverts stored parity on this write (test hook)
rd_perr  out  1  parity error flag, qualified by rd_valid

Behaviour:
Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- Reset clears wr_ptr and rd_ptr to 0; FSM to IDLE; rd_valid, rd_last, rd_perr and rd_data to 0; rd_ready goes to 1 on the first clock after reset.
- Memory contents are not reset.
- Reset mid-burst aborts the burst; no further rd_valid is issued.

Write path:
- wr_en writes at the selected address.
- wr_ptr increments only when wr_use_ext=0.
- Pointers wrap from DEPTH-1 to 0.
- wr_ptr_load has priority over the increment in the same cycle.
- External address >= DEPTH: write is dropped.

Read FSM (IDLE, WAIT, OUT):
- On accept, latch start address, remaining count = rd_len, wait = rd_wait; rd_ready drops.
- Acceptance cycle counts as cycle 0.
- IDLE -> WAIT if rd_wait>0, else IDLE -> OUT.
- WAIT counts rd_wait cycles, then -> OUT.
- OUT samples memory at the burst address and registers rd_data.
- rd_valid is high in the cycle after OUT.
- First word latency: rd_valid at cycle 1+rd_wait after accept.
- Each subsequent word adds 1+rd_wait cycles.
- After the last word, return to IDLE; rd_ready is high the cycle after rd_last.

Burst addressing:
- Burst address increments per word with wrap at DEPTH-1.
- With rd_use_ext=0, rd_ptr advances by 1 per delivered word.
- rd_ptr_load during a burst takes effect and overrides that cycle's advance.
- External address >= DEPTH reads as 0.

Same-cycle read/write collision:
- Read and write to the same address in the same cycle is read-first: the read returns the old data.

Optional Feature:
Macro SCRATCH_PARITY_EN.
- Defined: each word stores an extra even-parity bit computed from wr_data, XORed with wr_par_flip.
- Defined: rd_perr = recomputed parity != stored parity, asserted with rd_valid.
- Undefined: no parity storage; rd_perr is tied to 0 and wr_par_flip is ignored. Port list is unchanged.

Test Plan:
1. Reset, wr_use_ext=0, write 0x1111..0x1114 (4 writes); rd_use_ext=0, rd_len=3, rd_wait=0 -> rd_valid at cycles 1,2,3,4 with 0x1111..0x1114; rd_last on the 4th word; rd_ptr=4.
2. rd_wait=2, rd_len=1, ext rd_addr=0 -> first word at cycle 3, second at cycle 6; rd_ready low from cycle 1 to cycle 6, high at cycle 7.
3. wr_ptr_load with ptr_base=DEPTH-1, write 0xAAAA then 0xBBBB -> locations DEPTH-1 and 0; burst from DEPTH-1 with rd_len=1 returns 0xAAAA, 0xBBBB.
4. Same cycle: write 0x5555 to addr 7 (which held 0x1234) while an OUT read targets addr 7 -> rd_data=0x1234; a later read returns 0x5555.
5. Assert reset during WAIT of a 4-word burst -> rd_valid never pulses; rd_data=0; rd_ready=1 after the first clock after release.
6. SCRATCH_PARITY_EN: write 0x0F0F with wr_par_flip=1, read back -> rd_perr=1 with rd_valid; with the macro undefined -> rd_perr=0.

Source files
------------

// File: rtl/onchip_scratchpad_if.sv
// onchip_scratchpad_if: write port, pointer control and read-burst handshake of the scratchpad.
// master drives requests and write data; slave is the scratchpad itself.
interface onchip_scratchpad_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAIT_W = 2,
    parameter int unsigned LEN_W  = 4
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_use_ext;
    logic              wr_ptr_load;
    logic              rd_ptr_load;
    logic [ADDR_W-1:0] ptr_base;
    logic              wr_par_flip;
    logic              rd_req;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_use_ext;
    logic [LEN_W-1:0]  rd_len;
    logic [WAIT_W-1:0] rd_wait;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_perr;

    modport master (
        output wr_en, wr_data, wr_addr, wr_use_ext, wr_ptr_load, rd_ptr_load, ptr_base,
               wr_par_flip, rd_req, rd_addr, rd_use_ext, rd_len, rd_wait,
        input  rd_ready, rd_valid, rd_data, rd_last, rd_perr
    );

    modport slave (
        input  wr_en, wr_data, wr_addr, wr_use_ext, wr_ptr_load, rd_ptr_load, ptr_base,
               wr_par_flip, rd_req, rd_addr, rd_use_ext, rd_len, rd_wait,
        output rd_ready, rd_valid, rd_data, rd_last, rd_perr
    );
endinterface

// File: rtl/onchip_scratchpad.sv
// onchip_scratchpad: single-clock scratchpad RAM with pointer/external writes and wait-stated read bursts.
// Optional per-word parity storage is built when SCRATCH_PARITY_EN is defined.
module onchip_scratchpad #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned WAIT_W = 2,
    parameter int unsigned LEN_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    onchip_scratchpad_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_burst_addr;
    logic [LEN_W-1:0]  r_remain;
    logic [WAIT_W-1:0] r_wait_cfg;
    logic [WAIT_W-1:0] r_wcnt;
    logic              r_use_ptr;
    logic              r_rd_ready;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic              r_rd_perr;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_accept;
    logic              w_fetch;
    logic              w_burst_done;
    logic              w_ready_nxt;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_start_addr;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_perr;

    function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    assign w_wr_addr    = bus.wr_use_ext ? bus.wr_addr : r_wr_ptr;
    assign w_wr_ok      = bus.wr_en && (32'(w_wr_addr) < DEPTH);
    assign w_start_addr = bus.rd_use_ext ? bus.rd_addr : r_rd_ptr;
    assign w_rd_ok      = 32'(r_burst_addr) < DEPTH;
    assign w_rd_word    = w_rd_ok ? r_mem[r_burst_addr] : '0;

    // Non-blocking write and read of the same word in one edge gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_addr] <= bus.wr_data;
        end
    end

`ifdef SCRATCH_PARITY_EN
    logic r_par [DEPTH];

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_par[w_wr_addr] <= (^bus.wr_data) ^ bus.wr_par_flip;
        end
    end

    assign w_perr = w_rd_ok && ((^w_rd_word) != r_par[r_burst_addr]);
`else
    logic w_unused_par_flip;
    assign w_unused_par_flip = bus.wr_par_flip;
    assign w_perr            = 1'b0;
`endif

    // Pointer loads win over the same-cycle post-increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (bus.wr_ptr_load) begin
                r_wr_ptr <= bus.ptr_base;
            end else if (bus.wr_en && !bus.wr_use_ext) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (bus.rd_ptr_load) begin
                r_rd_ptr <= bus.ptr_base;
            end else if (w_fetch && r_use_ptr) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (bus.rd_wait != '0) ? S_WAIT : S_OUT;
                end
            end
            S_WAIT: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (r_remain == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = (r_wait_cfg != '0) ? S_WAIT : S_OUT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // rd_ready stays low through the cycle carrying rd_last and the acceptance edge.
    always_comb begin
        w_accept     = 1'b0;
        w_fetch      = 1'b0;
        w_burst_done = 1'b0;
        w_ready_nxt  = 1'b0;
        w_accept     = (r_state == S_IDLE) && bus.rd_req && r_rd_ready;
        w_fetch      = (r_state == S_OUT);
        w_burst_done = w_fetch && (r_remain == '0);
        w_ready_nxt  = (r_state == S_IDLE) && !w_accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ready   <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_perr    <= 1'b0;
            r_rd_data    <= '0;
            r_burst_addr <= '0;
            r_remain     <= '0;
            r_wait_cfg   <= '0;
            r_wcnt       <= '0;
            r_use_ptr    <= 1'b0;
        end else begin
            r_rd_ready <= w_ready_nxt;
            r_rd_valid <= w_fetch;
            r_rd_last  <= w_burst_done;
            r_rd_perr  <= w_fetch && w_perr;
            if (w_fetch) begin
                r_rd_data <= w_rd_word;
            end
            if (w_accept) begin
                r_burst_addr <= w_start_addr;
                r_remain     <= bus.rd_len;
                r_wait_cfg   <= bus.rd_wait;
                r_wcnt       <= bus.rd_wait - WAIT_W'(1);
                r_use_ptr    <= !bus.rd_use_ext;
            end else if (w_fetch) begin
                r_burst_addr <= f_inc(r_burst_addr);
                r_remain     <= r_remain - LEN_W'(1);
                r_wcnt       <= r_wait_cfg - WAIT_W'(1);
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt - WAIT_W'(1);
            end
        end
    end

    assign bus.rd_ready = r_rd_ready;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_last  = r_rd_last;
    assign bus.rd_perr  = r_rd_perr;
    assign bus.rd_data  = r_rd_data;
endmodule

// File: tb/tb_onchip_scratchpad.sv
// tb_onchip_scratchpad: scoreboard bench; bursts push expected words, a negedge monitor pops and compares.
// Uses a non-power-of-2 depth so out-of-range addresses are reachable.
module tb_onchip_scratchpad;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 1000;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned WAIT_W = 2;
    localparam int unsigned LEN_W  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              perr;
        int unsigned       cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    onchip_scratchpad_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .LEN_W(LEN_W)) bus ();

    onchip_scratchpad #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W), .LEN_W(LEN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mdl   [DEPTH];
    logic              mflip [DEPTH];
    int unsigned       m_wr_ptr = 0;
    int unsigned       m_rd_ptr = 0;
    exp_t              sb [$];
    exp_t              mon_e;
    int unsigned       cyc = 0;
    int                n_tests = 0;
    int                n_fail = 0;
    bit                pend_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned nxt(input int unsigned a);
        return (a == DEPTH - 1) ? 0 : ((a + 1) % (1 << ADDR_W));
    endfunction

    function automatic logic exp_perr(input int unsigned a);
`ifdef SCRATCH_PARITY_EN
        return (a < DEPTH) ? mflip[a] : 1'b0;
`else
        return (a < DEPTH) ? 1'b0 : 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected word, including its cycle.
    always @(negedge clk) begin
        if (pend_ready) begin
            chk("ready_after_last", bus.rd_ready, 1);
            pend_ready = 1'b0;
        end
        if (!reset && bus.rd_valid) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_rd_valid");
            end else begin
                mon_e = sb.pop_front();
                chk("rd_data", bus.rd_data, mon_e.data);
                chk("rd_last", bus.rd_last, mon_e.last);
                chk("rd_perr", bus.rd_perr, mon_e.perr);
                chk("valid_cycle", cyc, mon_e.cyc);
                if (mon_e.last) begin
                    chk("ready_with_last", bus.rd_ready, 0);
                    pend_ready = 1'b1;
                end
            end
        end
    end

    task automatic do_write(input bit ext, input int unsigned addr, input logic [DATA_W-1:0] data,
                            input bit flip);
        int unsigned tgt;
        bus.wr_en       = 1'b1;
        bus.wr_use_ext  = ext;
        bus.wr_addr     = ADDR_W'(addr);
        bus.wr_data     = data;
        bus.wr_par_flip = flip;
        tgt = ext ? addr : m_wr_ptr;
        if (tgt < DEPTH) begin
            mdl[tgt]   = data;
            mflip[tgt] = flip;
        end
        if (!ext) m_wr_ptr = nxt(m_wr_ptr);
        @(negedge clk);
        bus.wr_en       = 1'b0;
        bus.wr_par_flip = 1'b0;
    endtask

    task automatic load_ptr(input bit rd, input int unsigned base);
        bus.ptr_base = ADDR_W'(base);
        if (rd) begin
            bus.rd_ptr_load = 1'b1;
            m_rd_ptr = base;
        end else begin
            bus.wr_ptr_load = 1'b1;
            m_wr_ptr = base;
        end
        @(negedge clk);
        bus.rd_ptr_load = 1'b0;
        bus.wr_ptr_load = 1'b0;
    endtask

    // Returns at the negedge right after the accepting edge; acc is the cycle count after that edge.
    task automatic issue_burst(input bit ext, input int unsigned addr, input int unsigned len,
                               input int unsigned wt, output int unsigned acc);
        int unsigned guard = 0;
        int unsigned a;
        exp_t e;
        acc = 0;
        while (!bus.rd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.rd_ready) begin
            chk("ready_timeout", bus.rd_ready, 1);
            return;
        end
        a   = ext ? addr : m_rd_ptr;
        acc = cyc + 1;
        for (int k = 0; k <= int'(len); k++) begin
            e.data = (a < DEPTH) ? mdl[a] : '0;
            e.last = (k == int'(len));
            e.perr = exp_perr(a);
            e.cyc  = acc + (k + 1) * (1 + wt);
            sb.push_back(e);
            a = nxt(a);
        end
        if (!ext) m_rd_ptr = a;
        bus.rd_req     = 1'b1;
        bus.rd_use_ext = ext;
        bus.rd_addr    = ADDR_W'(addr);
        bus.rd_len     = LEN_W'(len);
        bus.rd_wait    = WAIT_W'(wt);
        @(negedge clk);
        bus.rd_req = 1'b0;
        chk("ready_low_after_accept", bus.rd_ready, 0);
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while ((sb.size() != 0 || pend_ready) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic burst(input bit ext, input int unsigned addr, input int unsigned len,
                         input int unsigned wt);
        int unsigned acc;
        issue_burst(ext, addr, len, wt, acc);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    end

    initial begin
        int unsigned acc;
        int unsigned lcyc;
        int unsigned adv;
        bus.wr_en = 0; bus.wr_data = '0; bus.wr_addr = '0; bus.wr_use_ext = 0;
        bus.wr_ptr_load = 0; bus.rd_ptr_load = 0; bus.ptr_base = '0; bus.wr_par_flip = 0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.rd_use_ext = 0; bus.rd_len = '0; bus.rd_wait = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mdl[i]   = '0;
            mflip[i] = 1'b0;
        end

        repeat (2) @(negedge clk);
        chk("reset_rd_valid", bus.rd_valid, 0);
        chk("reset_rd_last", bus.rd_last, 0);
        chk("reset_rd_perr", bus.rd_perr, 0);
        chk("reset_rd_data", bus.rd_data, 0);
        chk("reset_rd_ready", bus.rd_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_first_clock", bus.rd_ready, 1);

        // Pointer writes then a pointer burst; rd_ptr must end at 4.
        for (int i = 0; i < 4; i++) do_write(0, 0, DATA_W'(16'h1111 + i), 0);
        burst(0, 0, 3, 0);

        // Fill the rest via the write pointer; it wraps back to 0.
        load_ptr(0, 4);
        for (int i = 4; i < int'(DEPTH); i++) do_write(0, 0, DATA_W'($urandom), bit'($urandom_range(0, 1)));
        burst(0, 0, 0, 0);
        do_write(0, 0, 16'hC0DE, 0);
        burst(1, 0, 0, 0);

        burst(1, 0, 1, 2);

        load_ptr(0, DEPTH - 1);
        do_write(0, 0, 16'hAAAA, 0);
        do_write(0, 0, 16'hBBBB, 0);
        burst(1, DEPTH - 1, 1, 0);

        // Write lands on the same edge the burst samples address 7.
        do_write(1, 7, 16'h1234, 0);
        issue_burst(1, 7, 0, 0, acc);
        do_write(1, 7, 16'h5555, 0);
        drain();
        burst(1, 7, 0, 0);

        burst(1, 998, 3, 1);
        do_write(1, 1005, 16'hDEAD, 0);
        burst(1, 5, 0, 0);
        burst(1, 1010, 1, 0);

        // rd_ptr_load mid-burst replaces the advance of that edge only.
        load_ptr(1, 50);
        issue_burst(0, 0, 3, 1, acc);
        @(negedge clk);
        bus.ptr_base    = ADDR_W'(200);
        bus.rd_ptr_load = 1'b1;
        lcyc = cyc + 1;
        @(negedge clk);
        bus.rd_ptr_load = 1'b0;
        adv = 0;
        for (int k = 0; k <= 3; k++) if (acc + (k + 1) * 2 > lcyc) adv++;
        m_rd_ptr = 200;
        for (int k = 0; k < int'(adv); k++) m_rd_ptr = nxt(m_rd_ptr);
        drain();
        burst(0, 0, 1, 0);

        do_write(1, 300, 16'h0F0F, 1);
        burst(1, 300, 0, 0);

        // Reset while waiting inside a 4-word burst.
        issue_burst(1, 20, 3, 3, acc);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("midreset_rd_valid", bus.rd_valid, 0);
        chk("midreset_rd_data", bus.rd_data, 0);
        chk("midreset_rd_ready", bus.rd_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_wr_ptr = 0;
        m_rd_ptr = 0;
        @(negedge clk);
        chk("ready_after_reset_release", bus.rd_ready, 1);
        repeat (12) @(negedge clk);
        burst(0, 0, 1, 0);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 2))
                0: do_write(bit'($urandom_range(0, 1)), $urandom_range(0, (1 << ADDR_W) - 1),
                            DATA_W'($urandom), bit'($urandom_range(0, 1)));
                1: load_ptr(bit'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
                default: burst(bit'($urandom_range(0, 1)), $urandom_range(0, (1 << ADDR_W) - 1),
                               $urandom_range(0, (1 << LEN_W) - 1), $urandom_range(0, (1 << WAIT_W) - 1));
            endcase
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
